ysyx_24100005_mem_arb: RTL and testbench

Two-master, single-port memory arbiter for the NPC core: shares the one memory/DPI access port between the instruction fetch unit (IFU) and the load/store unit (LSU). Each master gets one outstanding transaction at a time. A response timeout guards against a stalled memory model. Sits between IFU/LSU and the memory interface wrapper around `npcmem_read`/`npcmem_write`.

---
 rtl/ysyx_24100005_mem_arb.sv | 147 ++++++++++++++
 tb/tb_ysyx_24100005_mem_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_mem_arb.sv
// Two-master (IFU/LSU) single-port memory arbiter with one outstanding
// transaction and a response timeout that forces an error response.
// Optional build macro: YSYX_24100005_ARB_RR_EN selects round-robin tie
// breaking; without it the LSU always wins simultaneous requests.
// While rst is high every output is forced to 0.
module ysyx_24100005_mem_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read port
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    // LSU read/write port
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    // Memory port
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitIfu, StWaitLsu} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lsu_win;
    logic             timed_out;
    logic [DATA_W-1:0] resp_data;

`ifdef YSYX_24100005_ARB_RR_EN
    // 1 = LSU was granted last; the other master wins the next tie.
    logic last_grant_q, last_grant_d;

    // Round-robin history register, updated only on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign lsu_win = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
`else
    assign lsu_win = lsu_req_valid;
`endif

    // State and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timed_out = (cnt_q == CNT_LAST);
    // A real response beats a coincident timeout.
    assign resp_data = mem_resp_valid ? mem_rdata : '0;

    // Next-state and output decode; outputs held at 0 during reset.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        arb_err        = 1'b0;
`ifdef YSYX_24100005_ARB_RR_EN
        last_grant_d   = last_grant_q;
`endif
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    mem_req_valid = ifu_req_valid || lsu_req_valid;
                    if (lsu_win) begin
                        mem_addr      = lsu_addr;
                        mem_wen       = lsu_wen;
                        mem_wdata     = lsu_wdata;
                        mem_wmask     = lsu_wmask;
                        lsu_req_ready = mem_req_ready;
                    end else if (ifu_req_valid) begin
                        mem_addr      = ifu_addr;
                        ifu_req_ready = mem_req_ready;
                    end
                    if (mem_req_valid && mem_req_ready) begin
                        state_d = lsu_win ? StWaitLsu : StWaitIfu;
                        cnt_d   = '0;
`ifdef YSYX_24100005_ARB_RR_EN
                        last_grant_d = lsu_win;
`endif
                    end
                end
                StWaitIfu, StWaitLsu: begin
                    // Saturate at the limit so the counter never wraps.
                    if (!timed_out) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (mem_resp_valid || timed_out) begin
                        state_d = StIdle;
                        arb_err = !mem_resp_valid;
                        if (state_q == StWaitIfu) begin
                            ifu_resp_valid = 1'b1;
                            ifu_rdata      = resp_data;
                        end else begin
                            lsu_resp_valid = 1'b1;
                            lsu_rdata      = resp_data;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arb.sv
// Directed bench for ysyx_24100005_mem_arb (TIMEOUT = 8).
module tb_ysyx_24100005_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, arb_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_chk  = 0;
    int n_pass = 0;

    ysyx_24100005_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v, lsu_v, rdy, wen;
        logic [31:0] ia, la, wd, rd;
        logic [3:0]  wm;
        logic        e_irdy, e_lrdy, e_mv, e_wen;
        logic [31:0] e_ma, e_wd;
        logic [3:0]  e_wm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    vec_t vecs[7];
    logic exp_lsu;

    initial begin
        // ifu_v lsu_v rdy wen  ia  la  wd  rd  wm | irdy lrdy mv wen ma wd wm
        vecs[0] = '{0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0,
                    0, 0, 0, 0, 32'h0, 32'h0, 4'h0};
        vecs[1] = '{1, 0, 1, 0, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0413, 4'h0,
                    1, 0, 1, 0, 32'h8000_0000, 32'h0, 4'h0};
        vecs[2] = '{0, 1, 1, 0, 32'h0, 32'h8000_0100, 32'h0, 32'h1234_5678, 4'h0,
                    0, 1, 1, 0, 32'h8000_0100, 32'h0, 4'h0};
        vecs[3] = '{0, 1, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, 4'b0011,
                    0, 1, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011};
        vecs[4] = '{1, 0, 0, 0, 32'h8000_0004, 32'h0, 32'h0, 32'h0, 4'h0,
                    0, 0, 1, 0, 32'h8000_0004, 32'h0, 4'h0};
        vecs[5] = '{0, 1, 0, 1, 32'h0, 32'h8000_2000, 32'hA5A5_5A5A, 32'h0, 4'hF,
                    0, 0, 1, 1, 32'h8000_2000, 32'hA5A5_5A5A, 4'hF};
        // IFU alone while LSU write qualifiers are live: must not leak through.
        vecs[6] = '{1, 0, 1, 1, 32'h8000_0008, 32'h0, 32'hFFFF_FFFF, 32'hBEEF_0001, 4'hF,
                    1, 0, 1, 0, 32'h8000_0008, 32'h0, 4'h0};

        // Reset: outputs held at 0 even with a request present.
        clear_inputs();
        rst = 1;
        lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
        clear_inputs();
        rst = 0;
        step();
        mid();
        chk("idle_mem_req_valid", mem_req_valid, 0);
        chk("idle_ifu_resp", ifu_resp_valid, 0);
        chk("idle_lsu_resp", lsu_resp_valid, 0);
        chk("idle_arb_err", arb_err, 0);
        chk("idle_mem_addr", mem_addr, 0);

        // Simultaneous requests held across four transactions.
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000;
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_24100005_ARB_RR_EN
            exp_lsu = (i % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            mid();
            chk("tie_lsu_ready", lsu_req_ready, exp_lsu);
            chk("tie_ifu_ready", ifu_req_ready, !exp_lsu);
            chk("tie_mem_addr", mem_addr, exp_lsu ? 32'h8000_3000 : 32'h8000_0000);
            step();
            mem_resp_valid = 1; mem_rdata = 32'h100 + i;
            mid();
            chk("tie_wait_ready", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 0);
            chk("tie_lsu_resp", lsu_resp_valid, exp_lsu);
            chk("tie_ifu_resp", ifu_resp_valid, !exp_lsu);
            step();
            mem_resp_valid = 0;
        end
        clear_inputs();
        step();

        // Table: one arbitration cycle, then a one-cycle response if accepted.
        for (int v = 0; v < 7; v++) begin
            ifu_req_valid = vecs[v].ifu_v; ifu_addr = vecs[v].ia;
            lsu_req_valid = vecs[v].lsu_v; lsu_addr = vecs[v].la;
            lsu_wen = vecs[v].wen; lsu_wdata = vecs[v].wd; lsu_wmask = vecs[v].wm;
            mem_req_ready = vecs[v].rdy;
            mid();
            chk($sformatf("v%0d_ifu_ready", v), ifu_req_ready, vecs[v].e_irdy);
            chk($sformatf("v%0d_lsu_ready", v), lsu_req_ready, vecs[v].e_lrdy);
            chk($sformatf("v%0d_mem_valid", v), mem_req_valid, vecs[v].e_mv);
            chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].e_ma);
            chk($sformatf("v%0d_mem_wen", v), mem_wen, vecs[v].e_wen);
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].e_wd);
            chk($sformatf("v%0d_mem_wmask", v), mem_wmask, vecs[v].e_wm);
            step();
            clear_inputs();
            if (vecs[v].rdy && vecs[v].e_mv) begin
                mem_resp_valid = 1; mem_rdata = vecs[v].rd;
                mid();
                chk($sformatf("v%0d_ifu_resp", v), ifu_resp_valid, vecs[v].e_irdy);
                chk($sformatf("v%0d_lsu_resp", v), lsu_resp_valid, vecs[v].e_lrdy);
                chk($sformatf("v%0d_ifu_rdata", v), ifu_rdata,
                    vecs[v].e_irdy ? vecs[v].rd : 32'h0);
                chk($sformatf("v%0d_lsu_rdata", v), lsu_rdata,
                    vecs[v].e_lrdy ? vecs[v].rd : 32'h0);
                step();
                mem_resp_valid = 0;
                // Response lasts exactly one cycle; stray response in IDLE is dropped.
                mem_resp_valid = 1;
                mid();
                chk($sformatf("v%0d_after_resp", v), {ifu_resp_valid, lsu_resp_valid}, 0);
                chk($sformatf("v%0d_after_rdata", v), ifu_rdata | lsu_rdata, 0);
                step();
                clear_inputs();
            end
        end

        // Timeout: no response, error exactly 8 cycles after the handshake.
        lsu_req_valid = 1; lsu_addr = 32'h8000_4000; mem_req_ready = 1;
        mem_rdata = 32'hCAFE_F00D;
        mid();
        step();
        lsu_req_valid = 0; mem_req_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            mid();
            chk($sformatf("to_k%0d_resp", k), lsu_resp_valid, (k == 8));
            chk($sformatf("to_k%0d_err", k), arb_err, (k == 8));
            if (k == 8) chk("to_rdata", lsu_rdata, 0);
            step();
        end
        lsu_req_valid = 1;
        mid();
        chk("to_back_idle", mem_req_valid, 1);
        chk("to_err_cleared", arb_err, 0);
        step();

        // Response coinciding with the timeout cycle wins.
        mem_req_ready = 1;
        mid();
        step();
        lsu_req_valid = 0; mem_req_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) mem_resp_valid = 1;
            mid();
            if (k == 8) begin
                chk("rt_resp", lsu_resp_valid, 1);
                chk("rt_rdata", lsu_rdata, 32'hCAFE_F00D);
                chk("rt_err", arb_err, 0);
            end
            step();
        end
        clear_inputs();

        // Memory not ready for three cycles with IFU pending.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("nr_ifu_ready", ifu_req_ready, 0);
            chk("nr_mem_valid", mem_req_valid, 1);
            step();
        end
        mem_req_ready = 1;
        mid();
        chk("nr_hs_ready", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0; mem_req_ready = 0;
        mem_resp_valid = 1; mem_rdata = 32'h0000_0093;
        mid();
        chk("nr_resp", ifu_resp_valid, 1);
        chk("nr_rdata", ifu_rdata, 32'h0000_0093);
        step();
        clear_inputs();

        // Reset pulse in WAIT_LSU, then a late memory response.
        lsu_req_valid = 1; lsu_addr = 32'h8000_5000; mem_req_ready = 1;
        mid();
        step();
        clear_inputs();
        #2;
        rst = 1;
        mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
        #1;
        chk("rw_lsu_resp", lsu_resp_valid, 0);
        chk("rw_lsu_rdata", lsu_rdata, 0);
        chk("rw_arb_err", arb_err, 0);
        mid();
        rst = 0;
        step();
        mid();
        chk("rw_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rw_late_err", arb_err, 0);
        step();
        mem_resp_valid = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0020; mem_req_ready = 1;
        mid();
        chk("rw_ifu_ready", ifu_req_ready, 1);
        chk("rw_mem_addr", mem_addr, 32'h8000_0020);
        step();
        clear_inputs();
        mem_resp_valid = 1; mem_rdata = 32'h0000_0513;
        mid();
        chk("rw_ifu_resp", ifu_resp_valid, 1);
        chk("rw_ifu_rdata", ifu_rdata, 32'h0000_0513);
        step();
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
